// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and constants for the bit-serial subtractor
//
// Purpose: state encoding and default operand width used by serial_sub.
// Contents:
//   sub_state_t        - IDLE / RUN / DONE controller states
//   SUB_WIDTH_DEFAULT  - default operand and result width in bits
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEFAULT = 4;

endpackage : sub_pkg

// File: rtl/serial_sub_fs.sv
// rtl/serial_sub_fs.sv - single-bit full subtractor cell
//
// Purpose: combinational x - y - bi for one bit position.
// Ports:
//   x   in  minuend bit
//   y   in  subtrahend bit
//   bi  in  borrow-in
//   d   out difference bit
//   bo  out borrow-out (1 when x < y + bi)
module fs (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule : fs

// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial ripple subtractor, LSB first, one bit per clock
//
// Purpose: computes diff = a - b - bin (mod 2^WIDTH) through one fs cell with a
// registered borrow. Operands are latched on an accepted start; the result is
// held until the next accepted start.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, sampled only while ready=1
//   a      in   minuend, captured on accepted start
//   b      in   subtrahend, captured on accepted start
//   bin    in   borrow-in, captured on accepted start
//   ready  out  high when a start will be accepted (IDLE or DONE)
//   done   out  one-cycle pulse, result valid
//   diff   out  a - b - bin modulo 2^WIDTH
//   bout   out  final borrow-out (1 when a < b + bin, unsigned)
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  sub_state_t       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [IW-1:0]    r_idx;
  logic             r_borrow;
  logic             r_bout;
  logic             r_ready;
  logic             r_done;

  logic             w_d;
  logic             w_bo;

  fs u_fs (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            // Back-to-back accept from DONE behaves exactly like from IDLE.
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_idx    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ready  <= 1'b0;
            r_state  <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          // Difference bits enter at the MSB so the first (LSB) bit lands at
          // position 0 after WIDTH shifts.
          r_diff   <= {w_d, r_diff[WIDTH-1:1]};
          r_a      <= {1'b0, r_a[WIDTH-1:1]};
          r_b      <= {1'b0, r_b[WIDTH-1:1]};
          r_borrow <= w_bo;
          if (r_idx == LAST_IDX) begin
            // Wrap idx here so it never exceeds WIDTH-1 for any WIDTH.
            r_idx   <= '0;
            r_bout  <= w_bo;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ready = r_ready;
  assign done  = r_done;
  assign diff  = r_diff;
  assign bout  = r_bout;

endmodule : serial_sub

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking bench for serial_sub (WIDTH=4 directed, WIDTH=8 random)
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst;

  logic       start4, bin4;
  logic [3:0] a4, b4;
  logic       ready4, done4, bout4;
  logic [3:0] diff4;

  logic       start8, bin8;
  logic [7:0] a8, b8;
  logic       ready8, done8, bout8;
  logic [7:0] diff8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .bin   (bin4),
    .ready (ready4),
    .done  (done4),
    .diff  (diff4),
    .bout  (bout4)
  );

  serial_sub #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .ready (ready8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called right after start4 is driven at a negedge. Counts negedges until
  // done4 is seen (lat) and how many of those cycles showed ready4=1 first.
  task automatic wait_done4(output int lat, output int rdy_hi, input logic drop_start);
    lat = 0;
    rdy_hi = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (drop_start && lat == 1) begin
        start4 = 1'b0;
        a4 = 4'hF; b4 = 4'hF; bin4 = 1'b1;
      end
      if (done4) break;
      if (ready4) rdy_hi++;
    end
  endtask

  task automatic run4(input logic [3:0] ta, input logic [3:0] tb_, input logic tbin, input string tag);
    int lat, rh;
    logic [3:0] ed;
    logic       eb;
    ed = 4'((int'(ta) - int'(tb_) - int'(tbin)) & 15);
    eb = (int'(ta) < int'(tb_) + int'(tbin));
    a4 = ta; b4 = tb_; bin4 = tbin; start4 = 1'b1;
    wait_done4(lat, rh, 1'b1);
    check({tag, "_latency"}, lat, 5);
    check({tag, "_ready_low"}, rh, 0);
    check({tag, "_diff"}, {28'd0, diff4}, {28'd0, ed});
    check({tag, "_bout"}, {31'd0, bout4}, {31'd0, eb});
    check({tag, "_ready_done"}, {31'd0, ready4}, 1);
    @(negedge clk);
    check({tag, "_pulse_end"}, {31'd0, done4}, 0);
    check({tag, "_hold"}, {27'd0, bout4, diff4}, {27'd0, eb, ed});
  endtask

  initial begin
    int lat, rh, cnt, cyc, n, accepts, dones, gap;
    logic [8:0] expq[$];
    logic [8:0] ex;
    logic       pending;
    logic [7:0] va, vb;
    logic       vbin;

    rst = 1'b1;
    start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
    start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
    repeat (2) @(negedge clk);
    check("rst_ready4", {31'd0, ready4}, 1);
    check("rst_done4", {31'd0, done4}, 0);
    check("rst_diff4", {27'd0, bout4, diff4}, 0);
    check("rst_ready8", {31'd0, ready8}, 1);
    check("rst_res8", {22'd0, done8, bout8, diff8}, 0);
    rst = 1'b0;
    @(negedge clk);

    run4(4'b0111, 4'b0101, 1'b0, "t1");
    run4(4'b0011, 4'b0101, 1'b0, "t2a");
    run4(4'b0000, 4'b0000, 1'b1, "t2b");
    run4(4'b1111, 4'b0000, 1'b1, "t2c");

    // Held start through RUN: must not re-accept; DONE accepts back-to-back.
    a4 = 4'b1001; b4 = 4'b0011; bin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    a4 = 4'b1100; b4 = 4'b0100; bin4 = 1'b1;
    wait_done4(lat, rh, 1'b0);
    check("t3_first_latency", lat, 4);
    check("t3_first_ready_low", rh, 0);
    check("t3_first_result", {27'd0, bout4, diff4}, {27'd0, 1'b0, 4'b0110});
    wait_done4(lat, rh, 1'b1);
    check("t3_second_latency", lat, 5);
    check("t3_second_result", {27'd0, bout4, diff4}, {27'd0, 1'b0, 4'b0111});
    @(negedge clk);

    // Reset on the second RUN cycle.
    a4 = 4'b1111; b4 = 4'b0000; bin4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_ready", {31'd0, ready4}, 1);
    check("t4_result", {27'd0, bout4, diff4}, 0);
    check("t4_done", {31'd0, done4}, 0);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) cnt++;
    end
    check("t4_no_done", cnt, 0);
    run4(4'b0110, 4'b0110, 1'b0, "t4_after");
    run4(4'b0101, 4'b0110, 1'b1, "t4_after2");

    // WIDTH=8 random vectors against (a-b-bin) mod 256 plus borrow flag.
    n = 0; accepts = 0; dones = 0; cyc = 0; pending = 1'b0; gap = 0;
    va = 0; vb = 0; vbin = 0;
    while ((n < 1000 || pending || expq.size() != 0) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (done8) begin
        dones++;
        if (expq.size() == 0) begin
          check("r8_unexpected_done", 1, 0);
        end else begin
          ex = expq.pop_front();
          check("r8_result", {23'd0, bout8, diff8}, {23'd0, ex});
        end
      end
      if (!pending && n < 1000) begin
        va = 8'($urandom); vb = 8'($urandom); vbin = 1'($urandom);
        gap = $urandom_range(0, 3);
        pending = 1'b1;
        n++;
      end
      start8 = 1'b0;
      if (pending) begin
        if (gap > 0) gap--;
        else begin
          a8 = va; b8 = vb; bin8 = vbin; start8 = 1'b1;
          if (ready8) begin
            ex[7:0] = 8'((int'(va) - int'(vb) - int'(vbin)) & 255);
            ex[8]   = (int'(va) < int'(vb) + int'(vbin));
            expq.push_back(ex);
            accepts++;
            pending = 1'b0;
          end
        end
      end
    end
    check("r8_no_timeout", {31'd0, (cyc < 30000)}, 1);
    check("r8_accepts", accepts, 1000);
    check("r8_done_count", dones, accepts);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_sub
